// File: rtl/fir_to_float_pipe.sv
// fir_to_float_pipe
// Converts the PPU fields-intermediate form (sign, signed total exponent,
// normalised 1.frac) into an IEEE-754 binary float of width 1+E+M.
// Uses round-to-nearest-even. Overflow saturates to infinity. Underflow
// produces subnormals, or signed zero when FTZ=1. NaR and zero have their own
// encodings, and the block drives the IEEE status flags.
// The pipeline has 1..3 register stages and a single global stall: every
// stage advances when the output is empty or is being consumed.

module fir_to_float_pipe #(
  parameter int TE_BITS         = 10,
  parameter int MANT_SIZE       = 28,
  parameter int FLOAT_EXP_SIZE  = 8,
  parameter int FLOAT_MANT_SIZE = 23,
  parameter int FSIZE           = 1 + FLOAT_EXP_SIZE + FLOAT_MANT_SIZE,
  parameter int STAGES          = 2,
  parameter bit FTZ             = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 sign_i,
  input  logic [TE_BITS-1:0]   te_i,
  input  logic [MANT_SIZE-1:0] frac_i,
  input  logic                 is_zero_i,
  input  logic                 is_nar_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [FSIZE-1:0]     float_o,
  output logic                 inexact_o,
  output logic                 overflow_o,
  output logic                 underflow_o
);

  localparam int E   = FLOAT_EXP_SIZE;
  localparam int M   = FLOAT_MANT_SIZE;
  // Biased-exponent width: room for the sign and one rounding carry
  localparam int BEW = ((TE_BITS > E) ? TE_BITS : E) + 2;
  localparam int EW1 = BEW + 1;
  // Alignment window: hidden+mantissa on top, then guard, then sticky bits,
  // padded below so a saturated shift never loses a set bit
  localparam int TW  = MANT_SIZE + M + 2;
  localparam int SHW = $clog2(M + 3);

  localparam int BIAS_I    = (1 << (E - 1)) - 1;
  localparam int EXP_INF_I = (1 << E) - 1;

  localparam logic [BEW-1:0] BIAS_BE = BEW'(BIAS_I);
  localparam logic [BEW-1:0] ZERO_BE = BEW'(0);
  localparam logic [BEW-1:0] ONE_BE  = BEW'(1);
  localparam logic [BEW-1:0] SAT_BE  = BEW'(M + 2);
  localparam logic [SHW-1:0] SAT_SH  = SHW'(M + 2);
  localparam logic [EW1-1:0] EXP_INF = EW1'(EXP_INF_I);

  // Illegal parameter combinations stop elaboration
  if (FSIZE != 1 + FLOAT_EXP_SIZE + FLOAT_MANT_SIZE) begin : g_bad_fsize
    $error("fir_to_float_pipe: FSIZE must equal 1+FLOAT_EXP_SIZE+FLOAT_MANT_SIZE");
  end
  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("fir_to_float_pipe: STAGES must be 1, 2 or 3");
  end

  typedef struct packed {
    logic           nar;
    logic           zero;
    logic           sign;
    logic [BEW-1:0] be;
    logic [MANT_SIZE-1:0] frac;
  } dec_t;

  typedef struct packed {
    logic         nar;
    logic         zero;
    logic         sign;
    logic [E-1:0] exp;
    logic [M-1:0] mant;
    logic         inexact;
    logic         overflow;
    logic         underflow;
  } rnd_t;

  // Decode: special detection (NaR wins over zero) and the biased exponent
  function automatic dec_t decode_f(input logic s, input logic [TE_BITS-1:0] te,
                                    input logic [MANT_SIZE-1:0] fr,
                                    input logic z, input logic n);
    dec_t d;
    d.nar  = n;
    d.zero = z & ~n;
    d.sign = s;
    d.be   = {{(BEW - TE_BITS){te[TE_BITS-1]}}, te} + BIAS_BE;
    d.frac = fr;
    return d;
  endfunction

  // Align/round: a single right shift serves both ranges. Normals use a shift
  // of 0. Subnormals use a shift of 1-be, saturated at M+2. RNE is then applied
  // on (lsb, guard, sticky).
  function automatic rnd_t round_f(input dec_t d);
    rnd_t r;
    logic [TW-1:0]  t_v;
    logic [TW-1:0]  sh_v;
    logic [BEW-1:0] dist_v;
    logic [SHW-1:0] amt_v;
    logic [M+1:0]   sum_v;
    logic [EW1-1:0] exp_v;
    logic           tiny_v;
    logic           guard_v;
    logic           sticky_v;
    logic           up_v;
    tiny_v = d.be[BEW-1] | (d.be == ZERO_BE);
    dist_v = ONE_BE - d.be;
    if (!tiny_v) begin
      amt_v = {SHW{1'b0}};
    end else if (dist_v > SAT_BE) begin
      amt_v = SAT_SH;
    end else begin
      amt_v = dist_v[SHW-1:0];
    end
    t_v      = {d.frac, {(M + 2){1'b0}}};
    sh_v     = t_v >> amt_v;
    guard_v  = sh_v[MANT_SIZE];
    sticky_v = |sh_v[MANT_SIZE-1:0];
    up_v     = guard_v & (sh_v[MANT_SIZE+1] | sticky_v);
    // Bit M is the hidden position; bit M+1 catches a normal's rounding carry
    sum_v    = {1'b0, sh_v[TW-1 -: M+1]} + {{(M + 1){1'b0}}, up_v};
    if (tiny_v) begin
      exp_v = {{(EW1 - 1){1'b0}}, sum_v[M]};
    end else begin
      exp_v = {1'b0, d.be} + {{(EW1 - 1){1'b0}}, sum_v[M+1]};
    end
    r.nar  = d.nar;
    r.zero = d.zero;
    r.sign = d.sign;
    if (tiny_v && FTZ) begin
      r.exp       = {E{1'b0}};
      r.mant      = {M{1'b0}};
      r.inexact   = 1'b1;
      r.overflow  = 1'b0;
      r.underflow = 1'b1;
    end else if (exp_v >= EXP_INF) begin
      r.exp       = {E{1'b1}};
      r.mant      = {M{1'b0}};
      r.inexact   = 1'b1;
      r.overflow  = 1'b1;
      r.underflow = 1'b0;
    end else begin
      r.exp       = exp_v[E-1:0];
      r.mant      = sum_v[M-1:0];
      r.inexact   = guard_v | sticky_v;
      r.overflow  = 1'b0;
      r.underflow = tiny_v & (guard_v | sticky_v);
    end
    return r;
  endfunction

  // Pack: final float word plus {inexact, overflow, underflow}
  function automatic logic [FSIZE+2:0] pack_f(input rnd_t r);
    logic [FSIZE+2:0] w;
    if (r.nar) begin
      w = {1'b0, {E{1'b1}}, 1'b1, {(M - 1){1'b0}}, 3'b000};
    end else if (r.zero) begin
      w = {(FSIZE + 3){1'b0}};
    end else begin
      w = {r.sign, r.exp, r.mant, r.inexact, r.overflow, r.underflow};
    end
    return w;
  endfunction

  logic             advance_s;
  dec_t             dec_s;
  dec_t             s2_in_s;
  logic             s2_in_v_s;
  rnd_t             rnd_s;
  rnd_t             s3_in_s;
  logic             s3_in_v_s;
  logic [FSIZE+2:0] pack_s;

  assign advance_s  = ~out_valid_o | out_ready_i;
  assign in_ready_o = advance_s;
  assign dec_s      = decode_f(sign_i, te_i, frac_i, is_zero_i, is_nar_i);

  if (STAGES >= 2) begin : g_s1_reg
    dec_t s1_r;
    logic s1_v_r;
    // Decode-stage register: shifts on advance, a bubble enters as valid=0
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_v_r <= 1'b0;
      end else if (advance_s) begin
        s1_v_r <= in_valid_i;
        s1_r   <= dec_s;
      end
    end
    assign s2_in_s   = s1_r;
    assign s2_in_v_s = s1_v_r;
  end else begin : g_s1_comb
    assign s2_in_s   = dec_s;
    assign s2_in_v_s = in_valid_i;
  end

  assign rnd_s = round_f(s2_in_s);

  if (STAGES == 3) begin : g_s2_reg
    rnd_t s2_r;
    logic s2_v_r;
    // Round-stage register: shifts on advance together with the other stages
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_v_r <= 1'b0;
      end else if (advance_s) begin
        s2_v_r <= s2_in_v_s;
        s2_r   <= rnd_s;
      end
    end
    assign s3_in_s   = s2_r;
    assign s3_in_v_s = s2_v_r;
  end else begin : g_s2_comb
    assign s3_in_s   = rnd_s;
    assign s3_in_v_s = s2_in_v_s;
  end

  assign pack_s = pack_f(s3_in_s);

  // Output register: holds the result and flags steady while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      float_o     <= {FSIZE{1'b0}};
      inexact_o   <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (advance_s) begin
      out_valid_o <= s3_in_v_s;
      {float_o, inexact_o, overflow_o, underflow_o} <= pack_s;
    end
  end

endmodule

// File: tb/tb_fir_to_float_pipe.sv
// Bench for fir_to_float_pipe. Four instances share the data inputs:
// instance 0 STAGES=2, instance 1 STAGES=1, instance 2 STAGES=3, and
// instance 3 STAGES=2 with FTZ=1. Each instance has its own handshake.
// Expected results come from an exact arithmetic model of the float
// encoding: integer quotient and remainder with round-half-even.

module tb_fir_to_float_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  ix_w, ov_w, un_w;
  logic [31:0] float_w [4];
  logic        sign_b, zero_b, nar_b;
  logic [9:0]  te_b;
  logic [27:0] frac_b;

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    fir_to_float_pipe #(
      .STAGES((g == 1) ? 1 : ((g == 2) ? 3 : 2)),
      .FTZ(g == 3)
    ) u_dut (
      .clk(clk), .rst(rst),
      .in_valid_i(in_valid[g]), .in_ready_o(in_ready[g]),
      .sign_i(sign_b), .te_i(te_b), .frac_i(frac_b),
      .is_zero_i(zero_b), .is_nar_i(nar_b),
      .out_valid_o(out_valid[g]), .out_ready_i(out_ready[g]),
      .float_o(float_w[g]),
      .inexact_o(ix_w[g]), .overflow_o(ov_w[g]), .underflow_o(un_w[g])
    );
  end

  function automatic int stages_of(input int k);
    case (k)
      1: return 1;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  // Reference model: value = frac * 2^(te-27). Result word {float, I, O, U}.
  function automatic logic [34:0] model(input logic s, input int te, input logic [27:0] fr,
                                        input logic z, input logic n, input bit ftz);
    longint be, d, q, rem, half, bits;
    logic   ix, tiny;
    if (n) return {32'h7FC00000, 3'b000};
    if (z) return {32'h00000000, 3'b000};
    be   = longint'(te) + 64'sd127;
    tiny = (be <= 0);
    if (tiny && ftz) return {s, 31'd0, 3'b101};
    // mantissa units: 2^-23 of the float; normal uses 2^(be-127) scaling
    d = tiny ? (64'sd5 - be) : 64'sd4;
    if (d > 40) d = 40;
    q    = longint'(fr) >> d;
    rem  = longint'(fr) - (q << d);
    half = longint'(1) << (d - 1);
    ix   = (rem != 0);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (tiny) bits = q;
    else      bits = be * 64'sd8388608 + q - 64'sd8388608;
    if (bits >= 64'sd2139095040) return {s, 8'hFF, 23'd0, 3'b110};
    return {s, bits[30:0], ix, 1'b0, tiny & ix};
  endfunction

  task automatic gen_beat();
    int r, sel, te;
    logic [27:0] fr;
    r      = $urandom_range(0, 15);
    nar_b  = (r == 0) || (r == 2);
    zero_b = (r == 1) || (r == 2);
    sign_b = 1'($urandom_range(0, 1));
    sel    = $urandom_range(0, 3);
    case (sel)
      0: te = $urandom_range(0, 253) - 126;
      1: te = $urandom_range(0, 32) - 152;
      2: te = $urandom_range(120, 130);
      default: te = $urandom_range(0, 1023) - 512;
    endcase
    fr = {1'b1, 27'($urandom)};
    case ($urandom_range(0, 3))
      0: fr[3:0] = 4'b1000;
      1: fr[3:0] = 4'b0000;
      default: fr = fr;
    endcase
    te_b   = 10'(te);
    frac_b = fr;
  endtask

  task automatic send_one(input int k, input string name, input logic s, input int te,
                          input logic [27:0] fr, input logic z, input logic n,
                          input logic [34:0] exp_w);
    int lat;
    logic [34:0] got;
    @(negedge clk);
    sign_b = s; te_b = 10'(te); frac_b = fr; zero_b = z; nar_b = n;
    in_valid[k] = 1'b1; out_ready[k] = 1'b1;
    #1;
    n_checks++;
    if (in_ready[k] !== 1'b1) begin
      n_errors++; $display("FAIL %s in_ready: got %b want 1", name, in_ready[k]);
    end
    @(negedge clk);
    in_valid[k] = 1'b0;
    #1;
    lat = 1;
    while (out_valid[k] !== 1'b1 && lat < 8) begin
      @(negedge clk); #1; lat++;
    end
    n_checks++;
    if (lat != stages_of(k)) begin
      n_errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, stages_of(k));
    end
    got = {float_w[k], ix_w[k], ov_w[k], un_w[k]};
    n_checks++;
    if (got !== exp_w) begin
      n_errors++;
      $display("FAIL %s result: got %h flags(IOU) %b want %h flags(IOU) %b",
               name, got[34:3], got[2:0], exp_w[34:3], exp_w[2:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'b0000; out_ready = 4'b0000;
    sign_b = 1'b0; te_b = 10'd0; frac_b = 28'd0; zero_b = 1'b0; nar_b = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({out_valid[k], float_w[k], ix_w[k], ov_w[k], un_w[k]} !== 36'd0) begin
        n_errors++;
        $display("FAIL reset_state[%0d]: got v=%b f=%h fl=%b want all 0", k, out_valid[k],
                 float_w[k], {ix_w[k], ov_w[k], un_w[k]});
      end
    end
    rst = 1'b0;
    @(negedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (in_ready[k] !== 1'b1) begin
        n_errors++; $display("FAIL reset_ready[%0d]: got %b want 1", k, in_ready[k]);
      end
    end
  endtask

  task automatic test_normal();
    send_one(0, "one", 1'b0, 0, 28'h8000000, 1'b0, 1'b0, {32'h3F800000, 3'b000});
    send_one(0, "neg_0p75", 1'b1, -1, 28'hC000000, 1'b0, 1'b0, {32'hBF400000, 3'b000});
    send_one(1, "one_s1", 1'b0, 0, 28'h8000000, 1'b0, 1'b0, {32'h3F800000, 3'b000});
    send_one(2, "one_s3", 1'b0, 0, 28'h8000000, 1'b0, 1'b0, {32'h3F800000, 3'b000});
  endtask

  task automatic test_rounding();
    send_one(0, "tie_even", 1'b0, 0, 28'h8000008, 1'b0, 1'b0, {32'h3F800000, 3'b100});
    send_one(0, "tie_odd_up", 1'b0, 0, 28'h8000018, 1'b0, 1'b0, {32'h3F800002, 3'b100});
    send_one(0, "round_ovf", 1'b0, 127, 28'hFFFFFFF, 1'b0, 1'b0, {32'h7F800000, 3'b110});
  endtask

  task automatic test_extremes();
    send_one(0, "te128", 1'b0, 128, 28'h8000000, 1'b0, 1'b0, {32'h7F800000, 3'b110});
    send_one(0, "subnorm", 1'b0, -127, 28'h8000000, 1'b0, 1'b0, {32'h00400000, 3'b000});
    send_one(3, "ftz", 1'b0, -127, 28'h8000000, 1'b0, 1'b0, {32'h00000000, 3'b101});
  endtask

  task automatic test_specials();
    send_one(0, "nar", 1'b1, 5, 28'h8000000, 1'b0, 1'b1, {32'h7FC00000, 3'b000});
    send_one(0, "zero", 1'b1, 5, 28'h8000000, 1'b1, 1'b0, {32'h00000000, 3'b000});
    send_one(0, "nar_zero", 1'b0, 0, 28'h0000000, 1'b1, 1'b1, {32'h7FC00000, 3'b000});
  endtask

  // Random stream on instance k, checked in order against the model
  task automatic test_stream(input int k, input int n_beats, input int ready_pct,
                             input bit hold, input string name);
    logic [34:0] exp_q[$];
    logic [34:0] got, prev_word, e;
    logic prev_stall, pend;
    int sent, recv, cyc;
    sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0; pend = 1'b0; prev_word = 35'd0;
    while ((sent < n_beats || recv < n_beats) && cyc < 600) begin
      @(negedge clk);
      if (hold && cyc >= 8 && cyc < 13) out_ready[k] = 1'b0;
      else out_ready[k] = ($urandom_range(0, 99) < ready_pct);
      if (sent < n_beats) begin
        if (!pend) begin gen_beat(); pend = 1'b1; end
        in_valid[k] = 1'b1;
      end else begin
        in_valid[k] = 1'b0;
      end
      #1;
      got = {float_w[k], ix_w[k], ov_w[k], un_w[k]};
      n_checks++;
      if (in_ready[k] !== (~out_valid[k] | out_ready[k])) begin
        n_errors++; $display("FAIL %s in_ready: got %b want %b", name, in_ready[k],
                             ~out_valid[k] | out_ready[k]);
      end
      if (prev_stall) begin
        n_checks++;
        if (got !== prev_word || out_valid[k] !== 1'b1) begin
          n_errors++; $display("FAIL %s stall_hold: got %h v=%b want %h v=1", name, got,
                               out_valid[k], prev_word);
        end
      end
      if (out_valid[k] && out_ready[k]) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++; $display("FAIL %s extra_beat: got %h want none", name, got);
        end else begin
          e = exp_q.pop_front();
          recv++;
          if (got !== e) begin
            n_errors++;
            $display("FAIL %s beat%0d: got %h flags(IOU) %b want %h flags(IOU) %b",
                     name, recv, got[34:3], got[2:0], e[34:3], e[2:0]);
          end
        end
      end
      prev_stall = out_valid[k] & ~out_ready[k];
      prev_word  = got;
      if (in_valid[k] && in_ready[k]) begin
        exp_q.push_back(model(sign_b, int'($signed(te_b)), frac_b, zero_b, nar_b, k == 3));
        sent++;
        pend = 1'b0;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid[k] = 1'b0; out_ready[k] = 1'b1;
    n_checks++;
    if (recv != n_beats || exp_q.size() != 0) begin
      n_errors++; $display("FAIL %s count: got %0d beats want %0d", name, recv, n_beats);
    end
    repeat (4) begin
      @(negedge clk); #1;
      n_checks++;
      if (out_valid[k] !== 1'b0) begin
        n_errors++; $display("FAIL %s dup_after_drain: got valid %b want 0", name, out_valid[k]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    out_ready[0] = 1'b0;
    sign_b = 1'b0; te_b = 10'd3; frac_b = 28'h8000000; zero_b = 1'b0; nar_b = 1'b0;
    in_valid[0] = 1'b1;
    @(negedge clk);
    te_b = 10'd4;
    @(negedge clk);
    in_valid[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (out_valid[0] !== 1'b0) begin
      n_errors++; $display("FAIL rst_mid valid: got %b want 0", out_valid[0]);
    end
    rst = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (in_ready[0] !== 1'b1) begin
      n_errors++; $display("FAIL rst_mid in_ready: got %b want 1", in_ready[0]);
    end
    out_ready[0] = 1'b1;
    repeat (6) begin
      @(negedge clk); #1;
      n_checks++;
      if (out_valid[0] !== 1'b0) begin
        n_errors++; $display("FAIL rst_mid ghost_beat: got valid %b want 0", out_valid[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_rounding();
    test_extremes();
    test_specials();
    test_stream(0, 30, 100, 1'b0, "back_to_back_s2");
    test_stream(2, 30, 100, 1'b0, "back_to_back_s3");
    test_stream(0, 20, 50, 1'b1, "backpressure_s2");
    test_stream(1, 20, 50, 1'b1, "backpressure_s1");
    test_stream(2, 20, 50, 1'b1, "backpressure_s3");
    test_stream(3, 40, 70, 1'b0, "ftz_stream");
    test_stream(0, 60, 60, 1'b0, "random_s2");
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
